// File: rtl/exu_stall_ctrl_if.sv
// Handshake bundle between the EXU->WB pipeline register, the LSU, the muldiv unit and
// the stall controller. The controller uses the master view; its environment uses slave.
interface exu_stall_ctrl_if #(
    parameter int MD_TYPE_W = 3
) ();
    logic                 instr_valid;
    logic                 is_load;
    logic                 is_store;
    logic [MD_TYPE_W-1:0] muldiv_type;
    logic                 redirect_flush;
    logic                 mem_req_ready;
    logic                 mem_resp_valid;
    logic                 stall;
    logic                 muldiv_start;
    logic                 muldiv_kill;
    logic                 muldiv_done;
    logic                 mem_req_valid;
    logic                 wb_load_valid;
    logic                 mem_resp_discard;
    logic                 busy;
    logic                 mem_timeout;

    modport master (
        input  instr_valid, is_load, is_store, muldiv_type, redirect_flush,
               mem_req_ready, mem_resp_valid,
        output stall, muldiv_start, muldiv_kill, muldiv_done, mem_req_valid,
               wb_load_valid, mem_resp_discard, busy, mem_timeout
    );

    modport slave (
        output instr_valid, is_load, is_store, muldiv_type, redirect_flush,
               mem_req_ready, mem_resp_valid,
        input  stall, muldiv_start, muldiv_kill, muldiv_done, mem_req_valid,
               wb_load_valid, mem_resp_discard, busy, mem_timeout
    );
endinterface

// File: rtl/exu_stall_ctrl.sv
// Stall sequencer for the EXU->WB pipeline register: launches and tracks muldiv and
// load/store ops, arbitrates redirect flushes against stall and drains orphaned responses.
module exu_stall_ctrl #(
    parameter  int MULDIV_LAT  = 4,
    parameter  int MEM_TIMEOUT = 256,
    localparam int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    exu_stall_ctrl_if.master bus
);
    localparam int MD_W = $clog2(MULDIV_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        MD_BUSY,
        MEM_REQ,
        MEM_WAIT,
        DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [MD_W-1:0]  md_cnt, md_cnt_nxt;
    logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
    logic             ld_lat, ld_lat_nxt;
    logic             mem_timeout_q, timeout_set;

    logic stall_c, start_c, kill_c, done_c, req_c, wb_c, discard_c;
    logic launch, md_op, mem_op, flush, resp;

    assign flush  = bus.redirect_flush;
    assign resp   = bus.mem_resp_valid;
    assign launch = bus.instr_valid & ~flush;
    assign md_op  = (bus.muldiv_type != '0);
    assign mem_op = bus.is_load | bus.is_store;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            md_cnt        <= '0;
            to_cnt        <= '0;
            ld_lat        <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            md_cnt        <= md_cnt_nxt;
            to_cnt        <= to_cnt_nxt;
            ld_lat        <= ld_lat_nxt;
            mem_timeout_q <= mem_timeout_q | timeout_set;
        end
    end

    always_comb begin
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;
        to_cnt_nxt  = to_cnt;
        ld_lat_nxt  = ld_lat;
        timeout_set = 1'b0;
        stall_c     = 1'b0;
        start_c     = 1'b0;
        kill_c      = 1'b0;
        done_c      = 1'b0;
        req_c       = 1'b0;
        wb_c        = 1'b0;
        discard_c   = 1'b0;

        case (state)
            IDLE: begin
                if (launch && md_op) begin
                    start_c    = 1'b1;
                    stall_c    = 1'b1;
                    md_cnt_nxt = MD_W'(MULDIV_LAT - 1);
                    state_nxt  = MD_BUSY;
                end else if (launch && mem_op) begin
                    stall_c    = 1'b1;
                    ld_lat_nxt = bus.is_load;
                    state_nxt  = MEM_REQ;
                end
            end
            MD_BUSY: begin
                if (flush) begin
                    kill_c    = 1'b1;
                    state_nxt = IDLE;
                end else if (md_cnt == '0) begin
                    done_c    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall_c    = 1'b1;
                    md_cnt_nxt = md_cnt - 1'b1;
                end
            end
            MEM_REQ: begin
                req_c   = 1'b1;
                stall_c = ~flush;
                if (bus.mem_req_ready && flush) begin
                    state_nxt = DRAIN;
                end else if (bus.mem_req_ready) begin
                    to_cnt_nxt = '0;
                    state_nxt  = MEM_WAIT;
                end else if (flush) begin
                    state_nxt = IDLE;
                end
            end
            MEM_WAIT: begin
                stall_c = ~flush & ~resp;
                if (resp && flush) begin
                    discard_c = 1'b1;
                    state_nxt = IDLE;
                end else if (resp) begin
                    wb_c      = ld_lat;
                    state_nxt = IDLE;
                end else if (flush) begin
                    state_nxt = DRAIN;
                end else if (to_cnt != CNT_W'(MEM_TIMEOUT)) begin
                    to_cnt_nxt  = to_cnt + 1'b1;
                    timeout_set = (to_cnt_nxt == CNT_W'(MEM_TIMEOUT));
                end
            end
            DRAIN: begin
                // The held instruction stays stalled even on the drain cycle; it launches from IDLE.
                stall_c = ~flush & bus.instr_valid;
                if (resp) begin
                    discard_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.stall            = reset_n & stall_c;
    assign bus.muldiv_start     = reset_n & start_c;
    assign bus.muldiv_kill      = reset_n & kill_c;
    assign bus.muldiv_done      = reset_n & done_c;
    assign bus.mem_req_valid    = reset_n & req_c;
    assign bus.wb_load_valid    = reset_n & wb_c;
    assign bus.mem_resp_discard = reset_n & discard_c;
    assign bus.busy             = reset_n & (state != IDLE);
    assign bus.mem_timeout      = reset_n & mem_timeout_q;
endmodule

// File: tb/tb_exu_stall_ctrl.sv
// Randomized bench for exu_stall_ctrl, checked every cycle against an op-level model that
// tracks outstanding muldiv cycles, pending requests and owed responses.
module tb_exu_stall_ctrl;
    localparam int LAT = 3;
    localparam int TO  = 8;
    localparam int NUM_CYCLES = 3000;

    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    exu_stall_ctrl_if #(.MD_TYPE_W(3)) bus ();

    exu_stall_ctrl #(.MULDIV_LAT(LAT), .MEM_TIMEOUT(TO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: muldiv in flight with cycles left, request not yet accepted, response owed.
    bit md_active, req_out, resp_out, dropped, op_is_load, timeout_flag;
    int md_rem, waited;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", tag, cycle, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int phase);
        int resp_pct;
        int flush_pct;
        reset_n = !(cycle < 3 || $urandom_range(0, 249) == 0);
        resp_pct  = (phase == 1) ? 5 : 35;
        flush_pct = (phase == 1) ? 4 : 14;
        bus.instr_valid    = ($urandom_range(0, 99) < 75);
        bus.muldiv_type    = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        bus.is_load        = $urandom_range(0, 1) == 1;
        bus.is_store       = $urandom_range(0, 2) == 0;
        bus.redirect_flush = ($urandom_range(0, 99) < flush_pct);
        bus.mem_req_ready  = $urandom_range(0, 1) == 1;
        bus.mem_resp_valid = ($urandom_range(0, 99) < resp_pct);
    endtask

    task automatic modelCycle();
        bit fl, rsp, iv, md, mem, busy, launch;
        bit e_stall, e_start, e_kill, e_done, e_req, e_wb, e_disc;
        fl   = bus.redirect_flush;
        rsp  = bus.mem_resp_valid;
        iv   = bus.instr_valid;
        md   = bus.muldiv_type != 3'd0;
        mem  = bus.is_load | bus.is_store;
        busy = md_active | req_out | resp_out;
        launch = !busy && iv && !fl;

        if (!reset_n) begin
            {e_stall, e_start, e_kill, e_done, e_req, e_wb, e_disc} = '0;
            busy = 1'b0;
        end else begin
            e_start = launch && md;
            e_kill  = md_active && fl;
            e_done  = md_active && !fl && md_rem == 0;
            e_req   = req_out;
            e_wb    = resp_out && !dropped && rsp && !fl && op_is_load;
            e_disc  = resp_out && rsp && (dropped || fl);
            e_stall = !fl && ((launch && (md || mem)) || (md_active && md_rem != 0) || req_out
                              || (resp_out && !dropped && !rsp) || (resp_out && dropped && iv));
        end

        checkOutput("stall",            bus.stall,            e_stall);
        checkOutput("muldiv_start",     bus.muldiv_start,     e_start);
        checkOutput("muldiv_kill",      bus.muldiv_kill,      e_kill);
        checkOutput("muldiv_done",      bus.muldiv_done,      e_done);
        checkOutput("mem_req_valid",    bus.mem_req_valid,    e_req);
        checkOutput("wb_load_valid",    bus.wb_load_valid,    e_wb);
        checkOutput("mem_resp_discard", bus.mem_resp_discard, e_disc);
        checkOutput("busy",             bus.busy,             busy);
        checkOutput("mem_timeout",      bus.mem_timeout,      reset_n && timeout_flag);

        if (!reset_n) begin
            md_active = 0; req_out = 0; resp_out = 0; dropped = 0;
            op_is_load = 0; timeout_flag = 0; md_rem = 0; waited = 0;
        end else if (launch && md) begin
            md_active = 1;
            md_rem    = LAT - 1;
        end else if (launch && mem) begin
            req_out    = 1;
            op_is_load = bus.is_load;
        end else if (md_active) begin
            if (fl || md_rem == 0) md_active = 0;
            else md_rem--;
        end else if (req_out) begin
            if (bus.mem_req_ready) begin
                req_out  = 0;
                resp_out = 1;
                dropped  = fl;
                waited   = 0;
            end else if (fl) begin
                req_out = 0;
            end
        end else if (resp_out) begin
            if (rsp) begin
                resp_out = 0;
                dropped  = 0;
            end else if (!dropped && fl) begin
                dropped = 1;
            end else if (!dropped) begin
                waited++;
                if (waited >= TO) timeout_flag = 1;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.instr_valid = 0; bus.is_load = 0; bus.is_store = 0; bus.muldiv_type = '0;
        bus.redirect_flush = 0; bus.mem_req_ready = 0; bus.mem_resp_valid = 0;
        for (int c = 0; c < NUM_CYCLES; c++) begin
            cycle = c;
            @(negedge clock);
            applyStimulus((c / 500) % 2);
            #1;
            modelCycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
